io_reg_responder: RTL
=====================

Name: io_reg_responder

Overview:
- Peripheral-side responder for the 4 KB register window at 0x1000_0000–0x1000_0FFF.
- Receives a single-cycle access request carrying the 12-bit offset and answers with a registered ack and read data one cycle later.
- Holds the VGA, cursor, LED and SEG registers, synchronises the switches, buffers keyboard scancodes in a FIFO, and issues DMA start pulses.

Parameters:
- KBD_DEPTH, 8, keyboard FIFO depth in entries; power of two, at least 2.
- SW_W, 16, switch and LED width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request, one-cycle pulse, qualified by the regs-window enable.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr_off  in  12  byte offset within the window (addr[11:0]).
- wdata  in  32  write data.
- rdata  out  32  read data; valid while ack = 1.
- ack  out  1  response strobe, one cycle.
- err  out  1  unmapped offset; valid while ack = 1.
- sw_in  in  SW_W  raw asynchronous switch inputs.
- kbd_data  in  8  scancode from the keyboard receiver.
- kbd_valid  in  1  push strobe for kbd_data.
- dma_busy  in  1  DMA engine busy.
- vga_mode  out  32  VGA control register.
- cursor_pos  out  32  cursor register.
- led_out  out  SW_W  LED register.
- seg_out  out  32  seven-segment display value.
- dma_cfg  out  31  DMA configuration latched at start.
- dma_start  out  1  one-cycle start pulse.

Behaviour:
- Reset: all registers, outputs and FIFO state go to 0; the FSM goes to IDLE; the switch synchronisers clear.
- FSM has two states, IDLE and RESP.
  - IDLE with req = 1: capture the access, perform all side effects on this edge, register rdata and err, and move to RESP.
  - RESP: ack = 1 for exactly one cycle, then return to IDLE.
  - A req arriving while in RESP is ignored; the CPU stalls until ack.
- Latency: ack is asserted in the cycle after req. Back-to-back accesses are possible every 2 cycles.
- Register map (only word offsets are decoded):
  - 0x000 vga_mode: read/write, 32 bits.
  - 0x004 cursor_pos: read/write, 32 bits.
  - 0x008 switches: read-only; returns the 2-flop synchronised sw_in, zero-extended. Writes are ignored with err = 0.
  - 0x00C led_out: read/write; only the low SW_W bits are stored; read returns them zero-extended.
  - 0x010 seg_out: read/write, 32 bits.
  - 0x014 keyboard: read returns {22'b0, ovf, valid, data[7:0]}.
    - If the FIFO is non-empty: valid = 1, data = head entry, and the entry is popped.
    - If the FIFO is empty: valid = 0, data = 0.
    - The read clears the ovf bit. Writes are ignored.
  - 0x018 dma: read returns {dma_busy, dma_cfg}.
    - A write with dma_busy = 0 latches wdata[30:0] into dma_cfg and asserts dma_start on the following cycle, coincident with ack.
    - A write with dma_busy = 1 is dropped with err = 1.
  - Any other offset: rdata = 0, err = 1, no side effects.
- Read data is the register value before any write on the same edge. Writes and reads are never simultaneous.
- Keyboard FIFO is a circular buffer with read/write pointers and a count of log2(KBD_DEPTH)+1 bits.
  - kbd_valid pushes every cycle it is high, independent of the FSM.
  - Push when full: the byte is dropped and sticky ovf is set.
  - Push and pop on the same edge: both take effect and the count is unchanged.
    - Empty case: the pop returns valid = 0 and the pushed byte is stored.
    - Full case: no overflow.
  - Pointers wrap modulo KBD_DEPTH.
- Asserting reset mid-access aborts it: ack and dma_start go low immediately and the FIFO contents are discarded.

Test Plan:
- Reset, then read 0x000, 0x00C, 0x014 → each acks 1 cycle after req with rdata = 0 and err = 0; all outputs are 0.
- Write 0x00C with 0xDEAD_BEEF, then read it → led_out = 0xBEEF, rdata = 0x0000_BEEF; write 0x004 with 0x0012_0034 → cursor_pos follows on the ack cycle.
- Push 0x1C, 0x32 via kbd_valid, then read 0x014 three times → 0x11C, 0x132, 0x000.
- Push 9 bytes with KBD_DEPTH = 8, then read → the first byte is returned with ovf = 1 (rdata = 0x3xx); the next read has ovf = 0; the 9th byte is lost.
- Write 0x018 with 0x0000_0100 while dma_busy = 0 → dma_cfg = 0x100 and a single dma_start pulse with ack; repeat with dma_busy = 1 → no pulse, err = 1, dma_cfg unchanged.
- Read 0x01C and 0x002 → err = 1, rdata = 0; req pulsed during RESP is ignored (exactly one ack); drop rst_n mid-access → ack deasserts immediately.

Source files
------------

// File: rtl/io_reg_responder.sv
// +--------------------------------------------------------------------------+
// | io_reg_responder: register-window responder with VGA/cursor/LED/SEG      |
// | registers, switch synchroniser, keyboard FIFO and DMA start control.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module io_reg_responder #(
  parameter int KBD_DEPTH = 8,
  parameter int SW_W      = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [11:0]     addr_off,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            ack,
  output logic            err,
  input  logic [SW_W-1:0] sw_in,
  input  logic [7:0]      kbd_data,
  input  logic            kbd_valid,
  input  logic            dma_busy,
  output logic [31:0]     vga_mode,
  output logic [31:0]     cursor_pos,
  output logic [SW_W-1:0] led_out,
  output logic [31:0]     seg_out,
  output logic [30:0]     dma_cfg,
  output logic            dma_start
);

  localparam int PTR_W = $clog2(KBD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state, state_next;
  logic   capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ack = (state == RESP);

  // Address decode: only word-aligned offsets map to registers.
  logic       word_ok;
  logic [9:0] widx;
  logic       sel_vga, sel_cur, sel_led, sel_seg, sel_kbd, sel_dma;

  assign word_ok = (addr_off[1:0] == 2'b00);
  assign widx    = addr_off[11:2];
  assign sel_vga = word_ok && (widx == 10'd0);
  assign sel_cur = word_ok && (widx == 10'd1);
  assign sel_led = word_ok && (widx == 10'd3);
  assign sel_seg = word_ok && (widx == 10'd4);
  assign sel_kbd = word_ok && (widx == 10'd5);
  assign sel_dma = word_ok && (widx == 10'd6);

  // Two-flop switch synchroniser.
  logic [SW_W-1:0] sw_meta, sw_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end

  // Keyboard FIFO.
  logic [7:0]       kbd_mem [KBD_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic             fifo_empty, fifo_full;
  logic             kbd_read, pop, push_ok;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(KBD_DEPTH));
  assign kbd_read   = capture && !we && sel_kbd;
  assign pop        = kbd_read && !fifo_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = kbd_valid && (!fifo_full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < KBD_DEPTH; i++) kbd_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        kbd_mem[wr_ptr] <= kbd_data;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (kbd_read)                   ovf <= 1'b0;
      else if (kbd_valid && !push_ok) ovf <= 1'b1;
    end
  end

  // Read mux reflects register state before any write on the capture edge.
  logic [31:0] rd_val;
  logic        rd_err;

  always_comb begin
    rd_val = '0;
    rd_err = 1'b0;
    if (!word_ok) begin
      rd_err = 1'b1;
    end else begin
      case (widx)
        10'd0:   rd_val = vga_mode;
        10'd1:   rd_val = cursor_pos;
        10'd2:   rd_val = 32'(sw_sync);
        10'd3:   rd_val = 32'(led_out);
        10'd4:   rd_val = seg_out;
        10'd5:   rd_val = {22'b0, ovf, !fifo_empty,
                           (fifo_empty ? 8'h00 : kbd_mem[rd_ptr])};
        10'd6:   rd_val = {dma_busy, dma_cfg};
        default: rd_err = 1'b1;
      endcase
    end
    if (we && sel_dma && dma_busy) rd_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata      <= '0;
      err        <= 1'b0;
      vga_mode   <= '0;
      cursor_pos <= '0;
      led_out    <= '0;
      seg_out    <= '0;
      dma_cfg    <= '0;
      dma_start  <= 1'b0;
    end else begin
      dma_start <= capture && we && sel_dma && !dma_busy;
      if (capture) begin
        rdata <= rd_val;
        err   <= rd_err;
        if (we) begin
          if (sel_vga) vga_mode   <= wdata;
          if (sel_cur) cursor_pos <= wdata;
          if (sel_led) led_out    <= wdata[SW_W-1:0];
          if (sel_seg) seg_out    <= wdata;
          if (sel_dma && !dma_busy) dma_cfg <= wdata[30:0];
        end
      end
    end
  end

endmodule

`default_nettype wire
